// File: rtl/game_state.sv
// ---------------------------------------------------------------------------
// game_state
// Top-level play-state controller for the snake game. A four-state Moore FSM
// (BLACK, PLAY, PAUSE, DEAD) reacts to the held PS/2 make code and to the
// collision flag. Leaving BLACK requires a minimum dwell time, so that at
// least one full video frame of the start colour is shown before play begins.
//
// Parameters
//   DWELL_CYCLES : minimum clk cycles spent in BLACK before START is accepted
//   KEY_START    : PS/2 set-2 code that starts or resumes play (space)
//   KEY_PAUSE    : code that pauses play ('P')
//   KEY_RESTART  : code that restarts the game ('R')
//
// Ports
//   clk          : in,  system clock, all state changes on the rising edge
//   rst          : in,  asynchronous active-high reset
//   died         : in,  level, head overlaps body or is out of bounds
//   key_code     : in,  [7:0] last PS/2 make code, held until the next key
//   init_snake   : out, reload the snake to its initial position
//   screen_black : out, force the full screen to the start colour
//   screen_pause : out, freeze snake motion
// ---------------------------------------------------------------------------
module game_state #(
    parameter int         DWELL_CYCLES = 2100000,
    parameter logic [7:0] KEY_START    = 8'h29,
    parameter logic [7:0] KEY_PAUSE    = 8'h4D,
    parameter logic [7:0] KEY_RESTART  = 8'h2D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       died,
    input  logic [7:0] key_code,
    output logic       init_snake,
    output logic       screen_black,
    output logic       screen_pause
);

    typedef enum logic [1:0] {
        BLACK = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam logic [21:0] DWELL_MAX = 22'(DWELL_CYCLES);

    // Arrow keys (up, down, left, right) resume from PAUSE as well as START.
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    state_t      state_r;
    state_t      next_state_s;
    logic [21:0] dwell_cnt_r;
    logic        dwell_done_s;
    logic        resume_key_s;

    // Dwell satisfied and resume-key detection.
    always_comb begin
        dwell_done_s = (dwell_cnt_r == DWELL_MAX);
        resume_key_s = (key_code == KEY_UP)   || (key_code == KEY_DOWN) ||
                       (key_code == KEY_LEFT) || (key_code == KEY_RIGHT) ||
                       (key_code == KEY_START);
    end

    // Next-state logic. key_code is a held level, so it is evaluated every
    // cycle; a held RESTART cannot start play and a held START is a no-op in
    // PLAY because neither matches a transition condition there.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            BLACK: begin
                if (dwell_done_s && (key_code == KEY_START)) begin
                    next_state_s = PLAY;
                end else begin
                    next_state_s = BLACK;
                end
            end
            PLAY: begin
                if (key_code == KEY_RESTART) begin
                    next_state_s = BLACK;
                end else if (died) begin
                    next_state_s = DEAD;
                end else if (key_code == KEY_PAUSE) begin
                    next_state_s = PAUSE;
                end else begin
                    next_state_s = PLAY;
                end
            end
            PAUSE: begin
                // died is deliberately not looked at while paused.
                if (key_code == KEY_RESTART) begin
                    next_state_s = BLACK;
                end else if (resume_key_s) begin
                    next_state_s = PLAY;
                end else begin
                    next_state_s = PAUSE;
                end
            end
            DEAD: begin
                if (key_code == KEY_RESTART) begin
                    next_state_s = BLACK;
                end else begin
                    next_state_s = DEAD;
                end
            end
            default: begin
                next_state_s = BLACK;
            end
        endcase
    end

    // State register, dwell counter and registered Moore outputs. Outputs are
    // decoded from the state being loaded so they change on the same edge as
    // the state register and never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= BLACK;
            dwell_cnt_r  <= 22'd0;
            init_snake   <= 1'b1;
            screen_black <= 1'b1;
            screen_pause <= 1'b1;
        end else begin
            state_r <= next_state_s;

            // Counting only while staying in BLACK means every entry into
            // BLACK starts again from zero.
            if ((state_r == BLACK) && (next_state_s == BLACK)) begin
                if (dwell_done_s) begin
                    dwell_cnt_r <= dwell_cnt_r;
                end else begin
                    dwell_cnt_r <= dwell_cnt_r + 22'd1;
                end
            end else begin
                dwell_cnt_r <= 22'd0;
            end

            case (next_state_s)
                BLACK: begin
                    init_snake   <= 1'b1;
                    screen_black <= 1'b1;
                    screen_pause <= 1'b1;
                end
                PLAY: begin
                    init_snake   <= 1'b0;
                    screen_black <= 1'b0;
                    screen_pause <= 1'b0;
                end
                PAUSE, DEAD: begin
                    init_snake   <= 1'b0;
                    screen_black <= 1'b0;
                    screen_pause <= 1'b1;
                end
                default: begin
                    init_snake   <= 1'b1;
                    screen_black <= 1'b1;
                    screen_pause <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_state.sv
// ---------------------------------------------------------------------------
// tb_game_state
// Self-checking bench for game_state with DWELL_CYCLES=8. A behavioural model
// tracks the game phase and the number of cycles spent on the start screen,
// and every cycle the DUT outputs are compared with the outputs expected for
// the modelled phase. Directed scenarios come first, then random key/died/rst
// stimulus.
// ---------------------------------------------------------------------------
module tb_game_state;

    localparam int DW = 8;

    localparam int M_BLACK = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DEAD  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       died;
    logic [7:0] key_code;
    logic       init_snake;
    logic       screen_black;
    logic       screen_pause;

    int n_checks = 0;
    int n_fail   = 0;
    int mstate;
    int mdwell;

    always #5 clk = ~clk;

    game_state #(
        .DWELL_CYCLES(DW),
        .KEY_START   (8'h29),
        .KEY_PAUSE   (8'h4D),
        .KEY_RESTART (8'h2D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .died        (died),
        .key_code    (key_code),
        .init_snake  (init_snake),
        .screen_black(screen_black),
        .screen_pause(screen_pause)
    );

    function automatic logic [2:0] exp_out(input int s);
        if (s == M_BLACK) return 3'b111;
        if (s == M_PLAY)  return 3'b000;
        return 3'b001;
    endfunction

    task automatic check(input string tag);
        logic [2:0] obs;
        logic [2:0] exp;
        obs = {init_snake, screen_black, screen_pause};
        exp = exp_out(mstate);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Game rules applied to the inputs present just before a clock edge.
    task automatic model_step();
        case (mstate)
            M_BLACK: begin
                if (mdwell >= DW && key_code == 8'h29) mstate = M_PLAY;
                else mdwell++;
            end
            M_PLAY: begin
                if (key_code == 8'h2D) begin mstate = M_BLACK; mdwell = 0; end
                else if (died) mstate = M_DEAD;
                else if (key_code == 8'h4D) mstate = M_PAUSE;
            end
            M_PAUSE: begin
                if (key_code == 8'h2D) begin mstate = M_BLACK; mdwell = 0; end
                else if (key_code inside {8'h75, 8'h72, 8'h6B, 8'h74, 8'h29}) mstate = M_PLAY;
            end
            default: begin
                if (key_code == 8'h2D) begin mstate = M_BLACK; mdwell = 0; end
            end
        endcase
    endtask

    // One clock: predict, let the edge happen, compare 1 ns later.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Reset pulse entirely between two clock edges; outputs must respond
    // before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        mstate = M_BLACK;
        mdwell = 0;
        #1;
        check(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int hold;
        rst = 1'b1;
        died = 1'b0;
        key_code = 8'h00;
        mstate = M_BLACK;
        mdwell = 0;
        #1;
        check("reset_state");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Dwell with START held: 8 cycles of BLACK, then PLAY.
        key_code = 8'h29;
        for (int i = 0; i < 9; i++) cycle("dwell_start");
        // Held START in PLAY causes no further transition.
        for (int i = 0; i < 3; i++) cycle("held_start_play");

        // Pause then resume with an arrow key.
        key_code = 8'h4D;
        cycle("pause");
        key_code = 8'h75;
        cycle("resume_arrow");

        // died beats PAUSE; DEAD ignores START; RESTART leaves DEAD.
        died = 1'b1;
        key_code = 8'h4D;
        cycle("died_over_pause");
        died = 1'b0;
        key_code = 8'h29;
        for (int i = 0; i < 3; i++) cycle("dead_ignores_start");
        key_code = 8'h2D;
        cycle("dead_restart");

        // Held RESTART in BLACK never starts play, then START does.
        for (int i = 0; i < 20; i++) cycle("black_held_restart");
        key_code = 8'h29;
        cycle("black_start_after_dwell");

        // Async reset from PLAY, then the full dwell again.
        async_reset("async_rst_play");
        for (int i = 0; i < 9; i++) cycle("dwell_after_rst");

        // RESTART beats died in PLAY.
        died = 1'b1;
        key_code = 8'h2D;
        cycle("restart_over_died");
        died = 1'b0;

        // Random phase.
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: key_code = 8'h29;
                    3:       key_code = 8'h4D;
                    4:       key_code = 8'h2D;
                    5:       key_code = 8'h75;
                    6:       key_code = 8'h72;
                    7:       key_code = 8'h6B;
                    8:       key_code = 8'h74;
                    default: key_code = 8'($urandom_range(0, 255));
                endcase
                hold = $urandom_range(1, 12);
            end
            hold--;
            died = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
